pool_stream_ctrl: RTL and testbench
===================================

Name: pool_stream_ctrl

Overview:
- Sequences a 2x2, stride-2 max-pool stage over one raster-ordered feature-map plane. Sits between the conv-layer output stream and the next layer's input.
- Pixels arrive row by row. The block buffers each even row in pairs and assembles the 2x2 window on the odd row.
- It drives the codebase's 4-input signed max unit and emits one pooled result per window through a valid/ready handshake.

Parameters:
- BITWIDTH, 8, signed pixel width.
- IN_W, 28, input plane width in pixels. Must be even and >=2.
- IN_H, 28, input plane height in pixels. Must be even and >=2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a plane. Ignored unless state is IDLE.
- in_data  in  BITWIDTH  signed input pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  BITWIDTH  signed pooled pixel.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high while state is RUN or DRAIN.
- frame_done  out  1  one-cycle pulse when the last pooled pixel of the plane is accepted.

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous and active-high on rst. When rst is sampled high:
  - state = IDLE; counters = 0.
  - in_ready = 0, out_valid = 0, out_data = 0, busy = 0, frame_done = 0.
  - Line-buffer contents are don't-care.
- Reset mid-plane aborts the plane. No frame_done is issued and no partial output is flushed.
- State machine:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the last input pixel (row IN_H-1, col IN_W-1) is accepted.
  - DRAIN -> IDLE when the final out_valid beat is accepted. frame_done pulses in that same cycle.
  - start while not IDLE is ignored.
- Input accept: a beat is accepted when in_valid && in_ready.
  - in_ready = (state == RUN) && (!out_valid || out_ready).
  - in_ready is therefore held low while an unaccepted result is pending. This is conservative: it applies on every column.
- Counters:
  - col counts 0..IN_W-1 and row counts 0..IN_H-1. Both advance only on accepted beats.
  - col wraps to 0 and increments row.
  - row wraps to 0 on the last pixel.
- Even row (row[0] = 0):
  - Even col: latch the pixel into hold register p0.
  - Odd col: write {p0, in_data} into line-buffer entry col>>1. Depth is IN_W/2, each entry 2*BITWIDTH wide.
  - No output is produced on even rows.
- Odd row (row[0] = 1):
  - Even col: latch into p0.
  - Odd col: the window is a, b = line-buffer entry col>>1, c = p0, d = in_data.
  - The max unit computes the signed maximum combinationally.
  - On the next edge, out_data is registered with the max and out_valid is set.
- Latency: out_valid rises the cycle after the beat that completes the window.
- Output hold: out_valid and out_data hold until out_ready. out_valid clears on accept unless a new result loads in the same cycle. With the in_ready rule above, a new result cannot load in that cycle.
- Throughput: one input beat per cycle when out_ready is held high. This yields (IN_W/2)*(IN_H/2) outputs per plane.
- Arithmetic: all comparisons are signed two's complement. There is no width growth; output width is BITWIDTH.
- Simultaneous events:
  - start in the same cycle as rst: reset wins.
  - in_valid in IDLE or DRAIN: not accepted (in_ready = 0).
  - DRAIN completes in the same cycle the final result is accepted. frame_done pulses there; busy drops the next cycle.
- Line-buffer read/write: a line-buffer entry is never read and written in the same cycle. Even rows write only and odd rows read only.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: the registered result is max(window, 0), i.e. ReLU fused before output. A negative maximum is output as 0.
- Undefined: the raw signed maximum is output unchanged.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic 4x4 (IN_W = IN_H = 4), stream 0..15 with out_ready = 1:
  - outputs 5, 7, 13, 15 in order;
  - frame_done on the 4th accept;
  - busy falls the next cycle.
- All-negative 4x4, stream values -16..-1:
  - without macro: outputs -11, -9, -3, -1;
  - with POOL_RELU_EN: outputs 0, 0, 0, 0.
- Backpressure: hold out_ready = 0 for 3 cycles after the first out_valid.
  - in_ready stays 0 throughout; out_data is stable at 5.
  - No input is lost; the remaining outputs match the basic case.
- Reset mid-plane: assert rst after 6 accepted beats.
  - All outputs return to reset values.
  - A fresh start and full plane then gives 5, 7, 13, 15.
- Ignored start: pulse start during RUN.
  - Counters and outputs are unaffected.
- Ignored input in IDLE: drive in_valid = 1 in IDLE.
  - in_ready stays 0.
- Full 28x28 plane, value = col - row:
  - 196 outputs;
  - window (r, c) gives 2c + 1 - 2r;
  - frame_done exactly once.

Source files
------------

// File: rtl/pool_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pool_stream_ctrl
// Brief    : 2x2 / stride-2 signed max-pool sequencer for one raster plane.
//            Define POOL_RELU_EN to clamp negative results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pool_stream_ctrl #(
    parameter int BITWIDTH = 8,
    parameter int IN_W     = 28,
    parameter int IN_H     = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                frame_done
);

    localparam int c_CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int c_RW  = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int c_LBD = IN_W / 2;
    localparam int c_LBW = (c_LBD > 1) ? $clog2(c_LBD) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_CW-1:0]       r_col;
    logic [c_RW-1:0]       r_row;
    logic [BITWIDTH-1:0]   r_p0;
    logic [2*BITWIDTH-1:0] r_lb [0:c_LBD-1];
    logic [BITWIDTH-1:0]   r_out_data;
    logic                  r_out_valid;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_out_accept;
    logic                  w_last_col;
    logic                  w_last_px;
    logic                  w_win_done;
    logic [c_LBW-1:0]      w_lb_idx;
    logic [2*BITWIDTH-1:0] w_lb_rd;

    logic signed [BITWIDTH-1:0] w_a, w_b, w_c, w_d;
    logic signed [BITWIDTH-1:0] w_max_ab, w_max_cd, w_max;
    logic signed [BITWIDTH-1:0] w_result;

    assign w_in_ready   = (r_state == c_RUN) && (!r_out_valid || out_ready);
    assign w_accept     = in_valid && w_in_ready;
    assign w_out_accept = r_out_valid && out_ready;
    assign w_last_col   = (r_col == c_CW'(IN_W - 1));
    assign w_last_px    = w_last_col && (r_row == c_RW'(IN_H - 1));
    assign w_win_done   = w_accept && r_row[0] && r_col[0];
    assign w_lb_idx     = c_LBW'(r_col >> 1);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_RUN;
            c_RUN:   if (w_accept && w_last_px) w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_out_accept) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_px ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Left pixel of each horizontal pair waits here for its right neighbour.
    always_ff @(posedge clk) begin
        if (w_accept && !r_col[0]) begin
            r_p0 <= in_data;
        end
    end

    // Even rows only write the buffer, odd rows only read it.
    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0] && r_col[0]) begin
            r_lb[w_lb_idx] <= {r_p0, in_data};
        end
    end

    assign w_lb_rd = r_lb[w_lb_idx];

    // ------------------------------------------------------------------
    // 4-input signed max
    // ------------------------------------------------------------------
    assign w_a      = $signed(w_lb_rd[2*BITWIDTH-1:BITWIDTH]);
    assign w_b      = $signed(w_lb_rd[BITWIDTH-1:0]);
    assign w_c      = $signed(r_p0);
    assign w_d      = $signed(in_data);
    assign w_max_ab = (w_a > w_b) ? w_a : w_b;
    assign w_max_cd = (w_c > w_d) ? w_c : w_d;
    assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;

`ifdef POOL_RELU_EN
    assign w_result = w_max[BITWIDTH-1] ? '0 : w_max;
`else
    assign w_result = w_max;
`endif

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_win_done) begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign frame_done = (r_state == c_DRAIN) && w_out_accept;

endmodule
`default_nettype wire

// File: tb/tb_pool_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_stream_ctrl
// Brief    : Directed checks of pool_stream_ctrl on a 4x4 and a 28x28 plane.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_stream_ctrl;

    logic       clk;
    logic       rst;

    logic       start4, in_valid4, in_ready4, out_valid4, out_ready4, busy4, fd4;
    logic [7:0] in_data4, out_data4;
    logic       start28, in_valid28, in_ready28, out_valid28, out_ready28, busy28, fd28;
    logic [7:0] in_data28, out_data28;

    int n_tests = 0;
    int n_fail  = 0;
    int q4[$];
    int q28[$];
    int fd4_cnt  = 0;
    int fd4_at   = 0;
    int fd28_cnt = 0;

    pool_stream_ctrl #(.BITWIDTH(8), .IN_W(4), .IN_H(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .busy(busy4), .frame_done(fd4)
    );

    pool_stream_ctrl #(.BITWIDTH(8), .IN_W(28), .IN_H(28)) u_dut28 (
        .clk(clk), .rst(rst), .start(start28),
        .in_data(in_data28), .in_valid(in_valid28), .in_ready(in_ready28),
        .out_data(out_data28), .out_valid(out_valid28), .out_ready(out_ready28),
        .busy(busy28), .frame_done(fd28)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change just after the rising edge, so mid-cycle is a stable view.
    always @(negedge clk) begin
        if (out_valid4 && out_ready4) begin
            q4.push_back(int'($signed(out_data4)));
            if (fd4) fd4_at = q4.size();
        end
        if (fd4) fd4_cnt++;
        if (out_valid28 && out_ready28) q28.push_back(int'($signed(out_data28)));
        if (fd28) fd28_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pexp(input int v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start4_pulse();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic send4(input int v);
        bit done;
        done = 1'b0;
        in_valid4 = 1'b1;
        in_data4  = v[7:0];
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            done = in_ready4;
            tick();
        end
        in_valid4 = 1'b0;
        if (!done) check("send4_timeout", 0, 1);
    endtask

    task automatic send28(input int v);
        bit done;
        done = 1'b0;
        in_valid28 = 1'b1;
        in_data28  = v[7:0];
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            done = in_ready28;
            tick();
        end
        in_valid28 = 1'b0;
        if (!done) check("send28_timeout", 0, 1);
    endtask

    task automatic finish4();
        for (int i = 0; i < 10 && busy4; i++) tick();
        tick();
        check("drain4_idle", int'(busy4), 0);
    endtask

    task automatic check_plane4(input string tag, input int e0, input int e1,
                                input int e2, input int e3);
        int exp_q[4];
        exp_q = '{e0, e1, e2, e3};
        check({tag, "_count"}, q4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_out%0d", tag, i), (i < q4.size()) ? q4[i] : -999, exp_q[i]);
        end
    endtask

    task automatic clear4();
        q4.delete();
        fd4_cnt = 0;
        fd4_at  = 0;
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        start28 = 1'b0; in_valid28 = 1'b0; in_data28 = '0; out_ready28 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_in_ready",   int'(in_ready4),  0);
        check("rst_out_valid",  int'(out_valid4), 0);
        check("rst_out_data",   int'(out_data4),  0);
        check("rst_busy",       int'(busy4),      0);
        check("rst_frame_done", int'(fd4),        0);

        // in_valid while idle must not be taken
        in_valid4 = 1'b1;
        in_data4  = 8'd42;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_in_ready", int'(in_ready4), 0);
            tick();
        end
        in_valid4 = 1'b0;
        check("idle_no_output", q4.size(), 0);

        // basic 0..15
        clear4();
        start4_pulse();
        check("basic_busy", int'(busy4), 1);
        for (int v = 0; v < 16; v++) send4(v);
        check("basic_last_valid", int'(out_valid4), 1);
        check("basic_fd_pulse",   int'(fd4),        1);
        check("basic_busy_at_fd", int'(busy4),      1);
        tick();
        check("basic_busy_after", int'(busy4),      0);
        check("basic_fd_after",   int'(fd4),        0);
        check("basic_valid_after", int'(out_valid4), 0);
        check_plane4("basic", 5, 7, 13, 15);
        check("basic_fd_at", fd4_at, 4);
        check("basic_fd_cnt", fd4_cnt, 1);

        // all negative -16..-1
        clear4();
        start4_pulse();
        for (int v = -16; v < 0; v++) send4(v);
        finish4();
        check_plane4("neg", pexp(-11), pexp(-9), pexp(-3), pexp(-1));
        check("neg_fd_cnt", fd4_cnt, 1);

        // backpressure on the first result
        clear4();
        start4_pulse();
        for (int v = 0; v < 5; v++) send4(v);
        out_ready4 = 1'b0;
        send4(5);
        in_valid4 = 1'b1;
        in_data4  = 8'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready",  int'(in_ready4),  0);
            check("bp_out_valid", int'(out_valid4), 1);
            check("bp_out_data",  int'($signed(out_data4)), 5);
            tick();
        end
        out_ready4 = 1'b1;
        for (int v = 6; v < 16; v++) send4(v);
        finish4();
        check_plane4("bp", 5, 7, 13, 15);
        check("bp_fd_cnt", fd4_cnt, 1);

        // reset mid-plane, then a clean plane
        clear4();
        start4_pulse();
        for (int v = 0; v < 6; v++) send4(v);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready",  int'(in_ready4),  0);
        check("midrst_out_valid", int'(out_valid4), 0);
        check("midrst_out_data",  int'(out_data4),  0);
        check("midrst_busy",      int'(busy4),      0);
        check("midrst_fd",        int'(fd4),        0);
        tick();
        check("midrst_no_fd", fd4_cnt, 0);
        rst    = 1'b1;
        start4 = 1'b1;
        tick();
        rst    = 1'b0;
        start4 = 1'b0;
        check("rst_beats_start", int'(busy4), 0);
        clear4();
        start4_pulse();
        for (int v = 0; v < 16; v++) send4(v);
        finish4();
        check_plane4("postrst", 5, 7, 13, 15);
        check("postrst_fd_cnt", fd4_cnt, 1);

        // start during RUN is ignored
        clear4();
        start4_pulse();
        for (int v = 0; v < 3; v++) send4(v);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ign_start_busy", int'(busy4), 1);
        for (int v = 3; v < 16; v++) send4(v);
        finish4();
        check_plane4("ign_start", 5, 7, 13, 15);
        check("ign_start_fd_cnt", fd4_cnt, 1);

        // full 28x28 plane, pixel = col - row
        q28.delete();
        fd28_cnt = 0;
        start28 = 1'b1;
        tick();
        start28 = 1'b0;
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) send28(c - r);
        end
        for (int i = 0; i < 10 && busy28; i++) tick();
        tick();
        check("p28_idle", int'(busy28), 0);
        check("p28_count", q28.size(), 196);
        for (int i = 0; i < 196; i++) begin
            check($sformatf("p28_out%0d", i), (i < q28.size()) ? q28[i] : -999,
                  pexp(2 * (i % 14) + 1 - 2 * (i / 14)));
        end
        check("p28_fd_cnt", fd28_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
